udreg_n: RTL and testbench
==========================

Name: udreg_n

Overview:
- Parametrised up/down register; successor to the fixed 16-bit load/increment register.
- Adds configurable width, step, modulus and reset value, plus decrement, synchronous clear, wrap or saturate mode, terminal-count flags and an overflow pulse.
- Used as a program counter, address pointer or loop counter in the datapath.

Parameters:
- WIDTH, 16, register width in bits (>= 2).
- STEP, 1, increment/decrement amount (1 <= STEP <= MAX).
- MAX, 2**WIDTH-1, highest legal count value; the count space is 0..MAX (MAX <= 2**WIDTH-1).
- SAT, 0, 0 = modulo wrap at the boundaries; 1 = saturate at 0 and MAX.
- RESET_VAL, 0, value of Q after reset and after clr (must be <= MAX).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear to RESET_VAL.
- ld  in  1  load D.
- inc  in  1  count up by STEP.
- dec  in  1  count down by STEP.
- D  in  WIDTH  load data.
- Q  out  WIDTH  register value.
- tc_up  out  1  combinational; 1 when Q == MAX.
- tc_dn  out  1  combinational; 1 when Q == 0.
- ovf  out  1  registered one-cycle pulse; a boundary was crossed or clamped.

Behaviour:
- Reset
  - reset_n low: Q = RESET_VAL and ovf = 0 immediately, independent of clk.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation aborts any action in progress; nothing is retained.
- Update and priority
  - All updates occur on the rising clk edge.
  - Priority order: clr > ld > (inc xor dec).
  - inc and dec both high with no clr/ld: hold, ovf = 0.
  - No control active: hold, ovf = 0.
- clr: Q <= RESET_VAL, ovf <= 0.
- ld
  - Q <= D if D <= MAX; otherwise Q <= MAX (clamp). ovf <= 0.
  - Clamping on load is not flagged.
- inc only
  - Compute Q+STEP in WIDTH+1 bits, so there is no carry loss at MAX = 2**WIDTH-1.
  - Q+STEP <= MAX: Q <= Q+STEP, ovf <= 0.
  - Q+STEP > MAX, SAT=0: Q <= Q+STEP-(MAX+1), ovf <= 1.
  - Q+STEP > MAX, SAT=1: Q <= MAX, ovf <= 1. This includes inc while already at MAX.
- dec only
  - Q >= STEP: Q <= Q-STEP, ovf <= 0.
  - Q < STEP, SAT=0: Q <= Q+(MAX+1)-STEP, computed in WIDTH+1 bits, ovf <= 1.
  - Q < STEP, SAT=1: Q <= 0, ovf <= 1.
- ovf is high for exactly the one cycle following the flagged edge; consecutive flagged edges keep it high.
- tc_up/tc_dn are decoded from Q only, with zero latency. Both are high only if MAX == 0, which is illegal.
- Latency: every operation takes 1 cycle; a new command is accepted every cycle.

Optional Feature:
- Macro: UDREG_SHADOW_EN.
- Defined
  - Adds input restore (1) and output Q_prev (WIDTH).
  - Shadow register Q_prev: reset = RESET_VAL; captures the old Q on every accepted ld.
  - restore ranks between clr and ld. It sets Q <= Q_prev, leaves Q_prev unchanged, and sets ovf <= 0.
  - clr also sets Q_prev <= RESET_VAL.
- Undefined: neither port exists, no shadow register is built, and behaviour is exactly as above.

Test Plan:
- Reset: reset_n=0 mid-count (WIDTH=8, RESET_VAL=5) -> Q=5 and ovf=0 immediately, without a clk edge. Release -> Q holds until a command.
- Wrap up: WIDTH=4, MAX=9, STEP=3, SAT=0; ld D=8 then inc -> Q=1, ovf=1 for one cycle. Next inc -> Q=4, ovf=0.
- Wrap down / saturate: same config; from Q=1, dec -> Q=8, ovf=1. With SAT=1: from Q=1, dec -> Q=0, ovf=1; dec again -> Q=0, ovf=1, tc_dn=1.
- Priority: clr+ld+inc high -> Q=RESET_VAL. ld+inc with D=7 -> Q=7. inc+dec at Q=4 -> Q=4, ovf=0.
- Full-range carry and load clamp:
  - WIDTH=8, MAX=255, STEP=1: Q=255, inc -> Q=0, ovf=1, tc_up 1 -> 0.
  - MAX=9: ld D=15 -> Q=9, ovf=0.
- Shadow (UDREG_SHADOW_EN): Q=3, ld D=6 -> Q=6, Q_prev=3. restore -> Q=3, Q_prev=3. clr -> Q=Q_prev=RESET_VAL.

Source files
------------

// File: rtl/udreg_n.sv
// Parametrised up/down register with wrap/saturate, terminal-count flags and overflow pulse.
// Optional shadow/restore register enabled by defining UDREG_SHADOW_EN.
module udreg_n #(
    parameter int unsigned          WIDTH     = 16,
    parameter logic [WIDTH-1:0]     STEP      = WIDTH'(1),
    parameter logic [WIDTH-1:0]     MAX       = {WIDTH{1'b1}},
    parameter bit                   SAT       = 1'b0,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
`ifdef UDREG_SHADOW_EN
    input  logic             restore,
    output logic [WIDTH-1:0] Q_prev,
`endif
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             tc_up,
    output logic             tc_dn,
    output logic             ovf
);

    // One extra bit keeps the carry when MAX is the full 2**WIDTH-1 range.
    localparam logic [WIDTH:0] MAX_E  = {1'b0, MAX};
    localparam logic [WIDTH:0] MOD_E  = MAX_E + (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_E = {1'b0, STEP};

    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_wrap;
    logic [WIDTH:0]   dn_wrap;
    logic             up_over;
    logic             dn_under;

    assign up_sum   = {1'b0, Q} + STEP_E;
    assign up_wrap  = up_sum - MOD_E;
    assign dn_wrap  = {1'b0, Q} + MOD_E - STEP_E;
    assign up_over  = up_sum > MAX_E;
    assign dn_under = Q < STEP;

`ifdef UDREG_SHADOW_EN
    logic [WIDTH-1:0] qp_nxt;
`endif

    always_comb begin
        q_nxt   = Q;
        ovf_nxt = 1'b0;
`ifdef UDREG_SHADOW_EN
        qp_nxt  = Q_prev;
`endif
        if (clr) begin
            q_nxt = RESET_VAL;
`ifdef UDREG_SHADOW_EN
            qp_nxt = RESET_VAL;
        end else if (restore) begin
            q_nxt = Q_prev;
`endif
        end else if (ld) begin
            // Out-of-range loads clamp silently.
            q_nxt = (D > MAX) ? MAX : D;
`ifdef UDREG_SHADOW_EN
            qp_nxt = Q;
`endif
        end else if (inc && !dec) begin
            if (!up_over) begin
                q_nxt = up_sum[WIDTH-1:0];
            end else begin
                q_nxt   = SAT ? MAX : up_wrap[WIDTH-1:0];
                ovf_nxt = 1'b1;
            end
        end else if (dec && !inc) begin
            if (!dn_under) begin
                q_nxt = Q - STEP;
            end else begin
                q_nxt   = SAT ? '0 : dn_wrap[WIDTH-1:0];
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q   <= RESET_VAL;
            ovf <= 1'b0;
        end else begin
            Q   <= q_nxt;
            ovf <= ovf_nxt;
        end
    end

`ifdef UDREG_SHADOW_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) Q_prev <= RESET_VAL;
        else          Q_prev <= qp_nxt;
    end
`endif

    assign tc_up = (Q == MAX);
    assign tc_dn = (Q == '0);

endmodule

// File: tb/tb_udreg_n.sv
// Directed bench for udreg_n: three configurations sharing one control bus.
module tb_udreg_n;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       clr = 1'b0, ld = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [7:0] D = '0;
    logic [7:0] qa;
    logic [3:0] qb, qc;
    logic       tua, tda, oa, tub, tdb, ob, tuc, tdc, oc;
`ifdef UDREG_SHADOW_EN
    logic       restore = 1'b0;
    logic [7:0] qpa;
    logic [3:0] qpb, qpc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // a: full 8-bit range, RESET_VAL=5
    udreg_n #(.WIDTH(8), .STEP(8'd1), .MAX(8'd255), .SAT(1'b0), .RESET_VAL(8'd5)) u_a (
        .clk(clk), .reset_n(reset_n), .clr(clr),
`ifdef UDREG_SHADOW_EN
        .restore(restore), .Q_prev(qpa),
`endif
        .ld(ld), .inc(inc), .dec(dec), .D(D), .Q(qa),
        .tc_up(tua), .tc_dn(tda), .ovf(oa));

    // b: mod-10 wrap, step 3
    udreg_n #(.WIDTH(4), .STEP(4'd3), .MAX(4'd9), .SAT(1'b0), .RESET_VAL(4'd2)) u_b (
        .clk(clk), .reset_n(reset_n), .clr(clr),
`ifdef UDREG_SHADOW_EN
        .restore(restore), .Q_prev(qpb),
`endif
        .ld(ld), .inc(inc), .dec(dec), .D(D[3:0]), .Q(qb),
        .tc_up(tub), .tc_dn(tdb), .ovf(ob));

    // c: same range, saturating
    udreg_n #(.WIDTH(4), .STEP(4'd3), .MAX(4'd9), .SAT(1'b1), .RESET_VAL(4'd2)) u_c (
        .clk(clk), .reset_n(reset_n), .clr(clr),
`ifdef UDREG_SHADOW_EN
        .restore(restore), .Q_prev(qpc),
`endif
        .ld(ld), .inc(inc), .dec(dec), .D(D[3:0]), .Q(qc),
        .tc_up(tuc), .tc_dn(tdc), .ovf(oc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic c, input logic l, input logic i, input logic d, input logic [7:0] dv);
        clr = c; ld = l; inc = i; dec = d; D = dv;
        tick();
        clr = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0;
    endtask

    initial begin
        // async reset before any clock edge
        #1 reset_n = 1'b0;
        #1;
        chk("rst_qa", qa, 5);
        chk("rst_oa", oa, 0);
        chk("rst_qb", qb, 2);
        #1 reset_n = 1'b1;
        tick();
        chk("hold_qa", qa, 5);

        // full-range load, then carry out of 255; b/c clamp the load to 9
        cmd(0, 1, 0, 0, 8'd255);
        chk("ld255_qa", qa, 255);
        chk("ld255_tua", tua, 1);
        chk("clamp_qb", qb, 9);
        chk("clamp_ob", ob, 0);
        chk("clamp_tub", tub, 1);
        cmd(0, 0, 1, 0, 8'd0);
        chk("carry_qa", qa, 0);
        chk("carry_oa", oa, 1);
        chk("carry_tua", tua, 0);
        chk("carry_tda", tda, 1);
        chk("wrap9_qb", qb, 2);
        chk("sat9_qc", qc, 9);
        chk("sat9_oc", oc, 1);

        // async reset mid-cycle, away from the clock edge
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_qa", qa, 5);
        chk("midrst_oa", oa, 0);
        chk("midrst_qc", qc, 2);
        chk("midrst_oc", oc, 0);
        #1 reset_n = 1'b1;
        tick();
        chk("post_rst_qa", qa, 5);
        chk("post_rst_qb", qb, 2);

        // wrap up: 8 + 3 -> 1 in mod 10
        cmd(0, 1, 0, 0, 8'd8);
        chk("ld8_qb", qb, 8);
        cmd(0, 0, 1, 0, 8'd0);
        chk("wrapup_qb", qb, 1);
        chk("wrapup_ob", ob, 1);
        chk("satup_qc", qc, 9);
        chk("satup_oc", oc, 1);
        chk("inc_qa", qa, 9);
        chk("inc_oa", oa, 0);
        cmd(0, 0, 1, 0, 8'd0);
        chk("inc2_qb", qb, 4);
        chk("inc2_ob", ob, 0);
        chk("satmax_qc", qc, 9);
        chk("satmax_oc", oc, 1);
        tick();
        chk("ovf_drop_ob", ob, 0);
        chk("ovf_drop_oc", oc, 0);

        // wrap down / saturate down
        cmd(0, 1, 0, 0, 8'd1);
        cmd(0, 0, 0, 1, 8'd0);
        chk("wrapdn_qb", qb, 8);
        chk("wrapdn_ob", ob, 1);
        chk("satdn_qc", qc, 0);
        chk("satdn_oc", oc, 1);
        chk("satdn_tdc", tdc, 1);
        cmd(0, 0, 0, 1, 8'd0);
        chk("dn2_qb", qb, 5);
        chk("dn2_ob", ob, 0);
        chk("satdn2_qc", qc, 0);
        chk("satdn2_oc", oc, 1);
        chk("satdn2_tdc", tdc, 1);

        // priority
        cmd(1, 1, 1, 0, 8'd7);
        chk("pri_clr_qb", qb, 2);
        chk("pri_clr_qa", qa, 5);
        chk("pri_clr_oc", oc, 0);
        cmd(0, 1, 1, 0, 8'd7);
        chk("pri_ld_qb", qb, 7);
        chk("pri_ld_qa", qa, 7);
        cmd(0, 1, 0, 0, 8'd4);
        cmd(0, 0, 1, 1, 8'd0);
        chk("incdec_qb", qb, 4);
        chk("incdec_ob", ob, 0);
        chk("incdec_qa", qa, 4);

`ifdef UDREG_SHADOW_EN
        cmd(0, 1, 0, 0, 8'd3);
        cmd(0, 1, 0, 0, 8'd6);
        chk("sh_ld_qb", qb, 6);
        chk("sh_ld_qpb", qpb, 3);
        restore = 1'b1;
        tick();
        restore = 1'b0;
        chk("sh_rst_qb", qb, 3);
        chk("sh_rst_qpb", qpb, 3);
        cmd(1, 0, 0, 0, 8'd0);
        chk("sh_clr_qb", qb, 2);
        chk("sh_clr_qpb", qpb, 2);
        chk("sh_clr_qpa", qpa, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
